// File: rtl/loader_pkg.sv
// Shared types and constants for the UART memory loader: FSM states, command opcodes,
// response bytes and target indices.
package loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_LO,
    S_ADDR_HI,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_ACK
  } state_t;

  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_PING  = 4'h2;

  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] PONG = 8'hA5;
  localparam logic [7:0] NAK  = 8'hEE;

  localparam int TGT_VRAM = 0;
  localparam int TGT_CRAM = 1;
  localparam int TGT_VDP  = 2;

  // States in which a stalled sender aborts the frame.
  function automatic logic in_frame(input state_t s);
    return (s inside {S_ADDR_LO, S_ADDR_HI, S_LEN_LO, S_LEN_HI, S_DATA});
  endfunction

endpackage

// File: rtl/loader_timer.sv
// Inter-byte timeout: counts cycles since the last reload; expired is held high once
// TIMEOUT cycles have elapsed, until the next reload.
module loader_timer #(
  parameter int TIMEOUT = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic reload,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == CW'(TIMEOUT));

  always_comb begin
    cnt_d = cnt_q;
    if (reload)
      cnt_d = '0;
    else if (!expired)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_mem_loader.sv
// UART command loader: WRITE/PING framing into memory write strobes plus a one-byte reply.
// Define LOADER_CHECKSUM_EN to reply to WRITE with the mod-256 data sum instead of 0x06.
module uart_mem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter int NUM_TARGETS = 3,
  parameter int TIMEOUT     = 5000000,
  parameter int SEL_W       = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_wr,
  input  logic              tx_done,
  output logic [SEL_W-1:0]  mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_di,
  output logic              mem_we,
  output logic              busy,
  output logic              err
);

  state_t              state_q, state_d;
  logic [7:0]          resp_d;
  logic [7:0]          write_resp;
  logic                expired;
  logic                tgt_ok;

  logic [SEL_W-1:0]    tgt_q, tgt_d;
  logic [7:0]          addr_lo_q, addr_lo_d;
  logic [7:0]          len_lo_q, len_lo_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         rem_q, rem_d;
  logic                err_q, err_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_di_q, mem_di_d;
  logic [SEL_W-1:0]    mem_sel_q, mem_sel_d;
  logic                tx_wr_q, tx_wr_d;
  logic [7:0]          tx_data_q, tx_data_d;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          sum_q, sum_d;
  assign write_resp = sum_q;
`else
  assign write_resp = ACK;
`endif

  loader_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .reload  (rx_valid),
    .expired (expired)
  );

  assign tgt_ok = (int'(rx_data[3:0]) < NUM_TARGETS);

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    resp_d  = NAK;
    case (state_q)
      S_IDLE: if (rx_valid) begin
        if (rx_data[7:4] == OP_WRITE && tgt_ok) begin
          state_d = S_ADDR_LO;
        end else if (rx_data[7:4] == OP_PING) begin
          state_d = S_ACK;
          resp_d  = PONG;
        end else begin
          state_d = S_ACK;
          resp_d  = NAK;
        end
      end
      S_ADDR_LO: if (rx_valid) state_d = S_ADDR_HI; else if (expired) state_d = S_IDLE;
      S_ADDR_HI: if (rx_valid) state_d = S_LEN_LO;  else if (expired) state_d = S_IDLE;
      S_LEN_LO:  if (rx_valid) state_d = S_LEN_HI;  else if (expired) state_d = S_IDLE;
      S_LEN_HI: if (rx_valid) begin
        if ({rx_data, len_lo_q} == 16'd0) begin
          state_d = S_ACK;
          resp_d  = write_resp;
        end else begin
          state_d = S_DATA;
        end
      end else if (expired) begin
        state_d = S_IDLE;
      end
      // Leave one cycle after the last byte so its write strobe is issued while still in S_DATA.
      S_DATA: if (rem_q == 16'd0) begin
        state_d = S_ACK;
        resp_d  = write_resp;
      end else if (!rx_valid && expired) begin
        state_d = S_IDLE;
      end
      S_ACK: if (tx_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tgt_d      = tgt_q;
    addr_lo_d  = addr_lo_q;
    len_lo_d   = len_lo_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    err_d      = err_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_di_d   = mem_di_q;
    mem_sel_d  = mem_sel_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    tx_wr_d    = (state_d == S_ACK) && (state_q != S_ACK);
    tx_data_d  = tx_wr_d ? resp_d : tx_data_q;

    if (in_frame(state_q) && state_d == S_IDLE)
      err_d = 1'b1;

    if (rx_valid) begin
      case (state_q)
        S_IDLE: begin
          tgt_d = rx_data[SEL_W-1:0];
`ifdef LOADER_CHECKSUM_EN
          sum_d = 8'h00;
`endif
          if (state_d == S_ACK && resp_d == NAK)
            err_d = 1'b1;
        end
        S_ADDR_LO: addr_lo_d = rx_data;
        S_ADDR_HI: addr_d    = ADDR_W'({rx_data, addr_lo_q});
        S_LEN_LO:  len_lo_d  = rx_data;
        S_LEN_HI:  rem_d     = {rx_data, len_lo_q};
        S_DATA: begin
          if (rem_q != 16'd0) begin
            mem_we_d   = 1'b1;
            mem_addr_d = addr_q;
            mem_di_d   = rx_data;
            mem_sel_d  = tgt_q;
            addr_d     = addr_q + 1'b1;
            rem_d      = rem_q - 16'd1;
`ifdef LOADER_CHECKSUM_EN
            sum_d      = sum_q + rx_data;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
        S_ACK:   err_d = 1'b1;
        default: err_d = err_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tgt_q      <= '0;
      addr_lo_q  <= '0;
      len_lo_q   <= '0;
      addr_q     <= '0;
      rem_q      <= '0;
      err_q      <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_di_q   <= '0;
      mem_sel_q  <= '0;
      tx_wr_q    <= 1'b0;
      tx_data_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      tgt_q      <= tgt_d;
      addr_lo_q  <= addr_lo_d;
      len_lo_q   <= len_lo_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      err_q      <= err_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_di_q   <= mem_di_d;
      mem_sel_q  <= mem_sel_d;
      tx_wr_q    <= tx_wr_d;
      tx_data_q  <= tx_data_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_wr    = tx_wr_q;
  assign mem_sel  = mem_sel_q;
  assign mem_addr = mem_addr_q;
  assign mem_di   = mem_di_q;
  assign mem_we   = mem_we_q;
  assign busy     = (state_q != S_IDLE);
  assign err      = err_q;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Scoreboard bench for uart_mem_loader: frame-level reference model queues expected writes
// and replies; a negedge monitor pops and compares them and answers tx_wr with tx_done.
module tb_uart_mem_loader;

  localparam int ADDR_W = 14;
  localparam int NT     = 3;
  localparam int TO     = 300;

  typedef struct {
    int sel;
    int addr;
    int data;
  } wr_t;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [7:0]              rx_data = 8'h00;
  logic                    rx_valid = 1'b0;
  logic [7:0]              tx_data;
  logic                    tx_wr;
  logic                    tx_done = 1'b0;
  logic [$clog2(NT)-1:0]   mem_sel;
  logic [ADDR_W-1:0]       mem_addr;
  logic [7:0]              mem_di;
  logic                    mem_we;
  logic                    busy;
  logic                    err;

  int   checks = 0;
  int   errors = 0;
  wr_t  exp_wr[$];
  int   exp_tx[$];
  logic exp_err = 1'b0;
  int   tx_delay = 3;
  int   tx_cnt = 0;
  logic [7:0] tx_held = 8'h00;
  logic prev_we = 1'b0;
  logic [7:0] payload[$];

  uart_mem_loader #(.ADDR_W(ADDR_W), .NUM_TARGETS(NT), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_wr    (tx_wr),
    .tx_done  (tx_done),
    .mem_sel  (mem_sel),
    .mem_addr (mem_addr),
    .mem_di   (mem_di),
    .mem_we   (mem_we),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor and tx_done responder.
  always @(negedge clk) begin
    tx_done = 1'b0;
    if (rst) begin
      tx_cnt  = 0;
      prev_we = 1'b0;
    end else begin
      if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) begin
          tx_done = 1'b1;
          check("tx_data_held", tx_data, tx_held);
        end
      end
      if (mem_we) begin
        check("mem_we_not_back_to_back", prev_we, 0);
        check("write_expected", exp_wr.size() != 0, 1);
        if (exp_wr.size() != 0) begin
          wr_t e;
          e = exp_wr.pop_front();
          check("mem_sel", mem_sel, e.sel);
          check("mem_addr", mem_addr, e.addr);
          check("mem_di", mem_di, e.data);
        end
      end
      prev_we = mem_we;
      if (tx_wr) begin
        check("tx_expected", exp_tx.size() != 0, 1);
        if (exp_tx.size() != 0)
          check("tx_data", tx_data, exp_tx.pop_front());
        tx_held = tx_data;
        tx_cnt  = tx_delay;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat ($urandom_range(3, 11)) @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 2000; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    check(name, busy, 0);
  endtask

  task automatic frame_done(input string name);
    wait_idle({name, "_idle"});
    check({name, "_writes_left"}, exp_wr.size(), 0);
    check({name, "_replies_left"}, exp_tx.size(), 0);
    check({name, "_err"}, err, exp_err);
  endtask

  // Reference model of a complete WRITE frame using the bytes in payload.
  task automatic run_write(input int tgt, input int a16, input string name);
    int sum;
    int n;
    n   = payload.size();
    sum = 0;
    for (int i = 0; i < n; i++) begin
      exp_wr.push_back('{tgt, (a16 + i) % (1 << ADDR_W), int'(payload[i])});
      sum = sum + int'(payload[i]);
    end
`ifdef LOADER_CHECKSUM_EN
    exp_tx.push_back(sum % 256);
`else
    exp_tx.push_back(8'h06);
`endif
    send_byte(8'h10 | 8'(tgt));
    send_byte(8'(a16 & 255));
    send_byte(8'((a16 >> 8) & 255));
    send_byte(8'(n & 255));
    send_byte(8'((n >> 8) & 255));
    for (int i = 0; i < n; i++) send_byte(payload[i]);
    frame_done(name);
  endtask

  task automatic run_ping(input string name);
    exp_tx.push_back(8'hA5);
    send_byte(8'h20 | 8'($urandom_range(0, 15)));
    frame_done(name);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_err = 1'b0;
    exp_wr.delete();
    exp_tx.delete();
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_tx_wr", tx_wr, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_di", mem_di, 0);
    check("rst_mem_sel", mem_sel, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    @(negedge clk);

    payload = '{8'h11, 8'h22, 8'h33};
    run_write(0, 16'h0000, "write_vram");

    payload = '{8'hAA, 8'hBB};
    run_write(1, 16'h3FFF, "write_wrap");

    payload = '{};
    run_write(2, 16'h1234, "write_len0");

    run_ping("ping");

    for (int f = 0; f < 25; f++) begin
      tx_delay = $urandom_range(1, 10);
      if ($urandom_range(0, 3) == 0) begin
        run_ping("rand_ping");
      end else begin
        int n;
        n = $urandom_range(0, 6);
        payload = '{};
        for (int i = 0; i < n; i++) payload.push_back(8'($urandom_range(0, 255)));
        run_write($urandom_range(0, NT - 1), $urandom_range(0, 65535), "rand_write");
      end
    end

    // Byte arriving while the reply is outstanding is dropped and flagged.
    tx_delay = 40;
    exp_tx.push_back(8'hA5);
    send_byte(8'h20);
    exp_err = 1'b1;
    send_byte(8'h10);
    frame_done("ack_drop");
    tx_delay = 3;

    // Reset in the middle of a 4-byte write after two data bytes.
    exp_wr.push_back('{0, 16'h0100, 8'h5A});
    exp_wr.push_back('{0, 16'h0101, 8'hC3});
    send_byte(8'h10); send_byte(8'h00); send_byte(8'h01); send_byte(8'h04); send_byte(8'h00);
    send_byte(8'h5A); send_byte(8'hC3);
    check("midrst_writes_seen", exp_wr.size(), 0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_tx_wr", tx_wr, 0);
    check("midrst_tx_data", tx_data, 0);
    check("midrst_mem_we", mem_we, 0);
    check("midrst_mem_addr", mem_addr, 0);
    check("midrst_mem_di", mem_di, 0);
    check("midrst_busy", busy, 0);
    check("midrst_err", err, 0);
    rst = 1'b0;
    exp_err = 1'b0;
    @(negedge clk);
    check("postrst_mem_we", mem_we, 0);
    check("postrst_tx_wr", tx_wr, 0);
    run_ping("ping_after_rst");

    // Target out of range and unknown opcode both NAK.
    exp_tx.push_back(8'hEE);
    exp_err = 1'b1;
    send_byte(8'h13);
    frame_done("bad_target");
    exp_tx.push_back(8'hEE);
    send_byte(8'h70);
    frame_done("bad_opcode");

    // Sender stalls after one of five data bytes.
    do_reset();
    exp_wr.push_back('{0, 0, 8'h01});
    send_byte(8'h10); send_byte(8'h00); send_byte(8'h00); send_byte(8'h05); send_byte(8'h00);
    send_byte(8'h01);
    repeat (TO / 2) @(negedge clk);
    check("timeout_busy_before_expiry", busy, 1);
    check("timeout_err_before_expiry", err, 0);
    exp_err = 1'b1;
    frame_done("timeout");

    // Timer sits expired while idle; a new frame must still complete.
    payload = '{8'h01, 8'h02};
    run_write(2, 16'hFFFE, "write_after_timeout");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_mem_loader.md
UART_MEM_LOADER -- requirements
Module: uart_mem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, which sets the memory address width.
REQ-002 SHALL have parameter NUM_TARGETS, default 3, giving the number of writable targets (0=VRAM, 1=CRAM, 2=VDP registers).
REQ-003 SHALL have parameter TIMEOUT, default 5000000, giving the inter-byte timeout in clk cycles.
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  system clock; all logic on its rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 rx_data  input  8  received UART byte; valid only when rx_valid=1.
REQ-008 rx_valid  input  1  one-cycle pulse marking a new byte.
REQ-009 tx_data  output  8  byte to transmit; held stable until tx_done.
REQ-010 tx_wr  output  1  one-cycle transmit strobe.
REQ-011 tx_done  input  1  one-cycle pulse marking transmit complete.
REQ-012 mem_sel  output  $clog2(NUM_TARGETS)  target index for the current write.
REQ-013 mem_addr  output  ADDR_W  write address.
REQ-014 mem_di  output  8  write data.
REQ-015 mem_we  output  1  one-cycle write strobe.
REQ-016 busy  output  1  high whenever state is not S_IDLE.
REQ-017 err  output  1  sticky error flag; cleared only by rst.

Function
REQ-018 SHALL implement states S_IDLE, S_ADDR_LO, S_ADDR_HI, S_LEN_LO, S_LEN_HI, S_DATA, S_ACK.
REQ-019 In S_IDLE, a received byte SHALL be decoded as a command: bits[7:4] give the opcode, bits[3:0] give the target.
REQ-020 Opcode 1 (WRITE) with target < NUM_TARGETS SHALL go to S_ADDR_LO; the next four bytes SHALL be addr_lo, addr_hi, len_lo, len_hi.
REQ-021 The address SHALL be the 16-bit value {addr_hi, addr_lo} truncated to ADDR_W bits; the length SHALL be 16 bits.
REQ-022 len=0 SHALL skip S_DATA and go directly to S_ACK.
REQ-023 In S_DATA, each rx_valid SHALL produce mem_we=1 on the next cycle, with mem_addr/mem_di/mem_sel valid in that same cycle.
REQ-024 The address SHALL increment by 1 after each write and wrap modulo 2^ADDR_W.
REQ-025 After the len-th data byte, the state SHALL become S_ACK.
REQ-026 Opcode 2 (PING) SHALL go to S_ACK with response 0xA5.
REQ-027 Any other opcode, or target >= NUM_TARGETS, SHALL set err and go to S_ACK with response 0xEE.
REQ-028 In S_ACK, the block SHALL pulse tx_wr for exactly one cycle on entry, then wait for tx_done, then return to S_IDLE.
REQ-029 rx bytes arriving in S_ACK SHALL be dropped and SHALL set err.
REQ-030 The timeout counter SHALL reload on every rx_valid; when it expires outside S_IDLE and S_ACK, the block SHALL return to S_IDLE with no ack and no write, and SHALL set err.
REQ-031 If rx_valid and timeout expiry occur in the same cycle, the byte SHALL win and the counter SHALL reload.
REQ-032 mem_we SHALL never be asserted outside S_DATA, and never in two consecutive cycles.

Reset
REQ-033 On rst, the block SHALL set state=S_IDLE, tx_wr=0, tx_data=0x00, mem_we=0, mem_addr=0, mem_di=0, mem_sel=0, busy=0, err=0, and clear the checksum and counters.
REQ-034 rst asserted mid-frame SHALL abort the frame; no mem_we or tx_wr SHALL occur in the cycle after rst.

Configuration
REQ-035 With macro LOADER_CHECKSUM_EN defined, the WRITE response SHALL be the 8-bit modulo-256 sum of all data bytes (0x00 for len=0).
REQ-036 Without LOADER_CHECKSUM_EN, the WRITE response SHALL be the fixed byte 0x06 and no checksum logic SHALL be built.

Structure
REQ-037 Package loader_pkg SHALL hold the state enum, opcode constants (OP_WRITE=1, OP_PING=2), the response constants (ACK=0x06, PONG=0xA5, NAK=0xEE) and the target indices.
REQ-038 The inter-byte timeout counter SHALL be the sub-module loader_timer, with ports clk, rst, reload, expired.

Verification
REQ-039 Send 0x10,0x00,0x00,0x03,0x00,0x11,0x22,0x33 -> three writes to VRAM at 0x0000..0x0002 with data 11,22,33; ack 0x66 (CHECKSUM_EN) or 0x06 (without).
REQ-040 Send 0x11,0xFF,0x3F,0x02,0x00,0xAA,0xBB with ADDR_W=14 -> writes to CRAM at 0x3FFF then 0x0000 (wrap); ack 0x65.
REQ-041 Send 0x20 -> tx_data=0xA5 with one tx_wr pulse, no mem_we; send 0x13 (target 3) -> ack 0xEE and err=1.
REQ-042 Send 0x10,0x00,0x00,0x05,0x00,0x01, then go silent for TIMEOUT cycles -> state returns to S_IDLE, no ack, err=1, exactly one write.
REQ-043 Assert rst after the second data byte of a 4-byte write -> all outputs take reset values, and a following PING returns 0xA5.
REQ-044 Inject rx_valid while waiting for tx_done in S_ACK -> byte dropped, err=1, return to S_IDLE after tx_done.
